ref_freq_monitor: RTL and testbench

REF_FREQ_MONITOR -- requirements
Module: ref_freq_monitor

---
 rtl/ref_mon_pkg.sv | 18 +
 rtl/ref_sync_edge.sv | 31 +++
 rtl/ref_freq_monitor.sv | 187 ++++++++++++++++++
 tb/tb_ref_freq_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ref_mon_pkg.sv
// Shared constants and FSM encoding for the reference-frequency monitor.
package ref_mon_pkg;

  localparam int NCH_D      = 4;
  localparam int CW_D       = 16;
  localparam int AVG_D      = 3;
  localparam int TOL_D      = 2;
  localparam int LOCK_CNT_D = 4;
  localparam int ODW_D      = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_TRACK   = 2'd2,
    S_LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/ref_sync_edge.sv
// Two-flop synchroniser for an asynchronous reference, plus a third flop
// for a one-cycle rising-edge pulse. i_clr is a synchronous clear.
module ref_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_d,
  output logic o_edge
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (i_clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/ref_freq_monitor.sv
// Measures the REF_IN period in CLK cycles, averages it over 2^AVG periods,
// declares lock after LOCK_CNT stable windows and emits divided strobes.
module ref_freq_monitor
  import ref_mon_pkg::*;
#(
  parameter int NCH      = NCH_D,
  parameter int CW       = CW_D,
  parameter int AVG      = AVG_D,
  parameter int TOL      = TOL_D,
  parameter int LOCK_CNT = LOCK_CNT_D,
  parameter int ODW      = ODW_D
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pd,
  input  logic               i_ref_in,
  input  logic [NCH*ODW-1:0] i_div_o,
  output logic [CW-1:0]      o_period,
  output logic               o_period_vld,
  output logic               o_lock,
  output logic               o_ref_lost,
  output logic [NCH-1:0]     o_ce_out
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam int            NPW     = (AVG > 0) ? AVG : 1;
  localparam int            AW      = CW + AVG;
  localparam int            GW      = $clog2(LOCK_CNT + 1);

  state_e          r_state;
  logic [CW-1:0]   r_cnt, r_prev, r_period;
  logic [AW-1:0]   r_acc;
  logic [NPW-1:0]  r_nper;
  logic [GW-1:0]   r_good;
  logic            r_armed, r_vld, r_lock, r_lost;

  logic            w_edge, w_sat, w_win, w_in_tol, w_to_locked;
  logic [AW-1:0]   w_acc_nxt;
  logic [CW-1:0]   w_avg, w_diff;
  logic [GW-1:0]   w_good_nxt;
  logic [NCH-1:0]  w_ce;

  ref_sync_edge u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_pd),
    .i_d    (i_ref_in),
    .o_edge (w_edge)
  );

  // An edge in the same cycle as saturation wins: the reload hides it.
  assign w_sat       = ~w_edge & (r_cnt == CNT_MAX - 1'b1);
  assign w_win       = w_edge & r_armed & (r_state != S_IDLE) &
                       (r_nper == NPW'((2 ** AVG) - 1));
  assign w_acc_nxt   = r_acc + AW'(r_cnt);
  assign w_avg       = w_acc_nxt[AVG +: CW];
  assign w_diff      = (w_avg >= r_prev) ? (w_avg - r_prev) : (r_prev - w_avg);
  assign w_in_tol    = (w_diff <= CW'(TOL));
  assign w_good_nxt  = r_good + 1'b1;
  assign w_to_locked = w_win & (r_state == S_TRACK) & w_in_tol &
                       (w_good_nxt == GW'(LOCK_CNT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prev   <= '0;
      r_period <= '0;
      r_acc    <= '0;
      r_nper   <= '0;
      r_good   <= '0;
      r_armed  <= 1'b0;
      r_vld    <= 1'b0;
      r_lock   <= 1'b0;
      r_lost   <= 1'b0;
    end else if (i_pd) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prev   <= '0;
      r_acc    <= '0;
      r_nper   <= '0;
      r_good   <= '0;
      r_armed  <= 1'b0;
      r_vld    <= 1'b0;
      r_lock   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_vld <= 1'b0;

      if (w_edge)                r_cnt <= CW'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

      if (w_edge)     r_lost <= 1'b0;
      else if (w_sat) r_lost <= 1'b1;

      if (w_sat) begin
        r_state <= S_MEASURE;
        r_lock  <= 1'b0;
        r_armed <= 1'b0;
        r_acc   <= '0;
        r_nper  <= '0;
        r_good  <= '0;
      end else if (r_state == S_IDLE) begin
        r_state <= S_MEASURE;
      end else if (w_edge) begin
        // The first edge only opens the measurement; it has no period yet.
        if (!r_armed) begin
          r_armed <= 1'b1;
        end else if (!w_win) begin
          r_acc  <= w_acc_nxt;
          r_nper <= r_nper + 1'b1;
        end else begin
          r_acc    <= '0;
          r_nper   <= '0;
          r_period <= w_avg;
          r_vld    <= 1'b1;
          r_prev   <= w_avg;
          case (r_state)
            S_MEASURE: begin
              r_state <= S_TRACK;
              r_good  <= '0;
            end
            S_TRACK: begin
              if (w_in_tol) r_good <= w_good_nxt;
              else          r_good <= '0;
              if (w_to_locked) begin
                r_state <= S_LOCKED;
                r_lock  <= 1'b1;
              end
            end
            S_LOCKED: begin
              if (!w_in_tol) begin
                r_state <= S_TRACK;
                r_lock  <= 1'b0;
                r_good  <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [ODW-1:0] w_div, w_div_m1;
      logic [ODW-1:0] r_ch_cnt;
      logic           r_ce;

      assign w_div    = i_div_o[c*ODW +: ODW];
      assign w_div_m1 = (w_div == '0) ? '0 : (w_div - 1'b1);

      // Down-counter reloads with the current divide value on each strobe,
      // so a new divide value is picked up at the channel's next wrap.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_ch_cnt <= '0;
          r_ce     <= 1'b0;
        end else if (i_pd || w_to_locked) begin
          r_ch_cnt <= '0;
          r_ce     <= 1'b0;
        end else begin
          r_ce <= 1'b0;
          if ((r_state == S_LOCKED) && w_edge) begin
            if (r_ch_cnt == '0) begin
              r_ce     <= 1'b1;
              r_ch_cnt <= w_div_m1;
            end else begin
              r_ch_cnt <= r_ch_cnt - 1'b1;
            end
          end
        end
      end

      assign w_ce[c] = r_ce;
    end
  endgenerate

  assign o_period     = r_period;
  assign o_period_vld = r_vld;
  assign o_lock       = r_lock;
  assign o_ref_lost   = r_lost;
  assign o_ce_out     = w_ce & {NCH{r_state == S_LOCKED}};

endmodule

// File: tb/tb_ref_freq_monitor.sv
// Directed bench for ref_freq_monitor: table of steady reference patterns
// plus hand-written sequences for step, loss, strobes, power-down and reset.
module tb_ref_freq_monitor;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int ODW = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pd  = 1'b0;
  logic               ref_in = 1'b0;
  logic [NCH*ODW-1:0] div_o = '0;
  logic [CW-1:0]      period;
  logic               period_vld, lock, ref_lost;
  logic [NCH-1:0]     ce_out;

  ref_freq_monitor dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pd         (pd),
    .i_ref_in     (ref_in),
    .i_div_o      (div_o),
    .o_period     (period),
    .o_period_vld (period_vld),
    .o_lock       (lock),
    .o_ref_lost   (ref_lost),
    .o_ce_out     (ce_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference generator: rising edge every 'cur' CLKs, odd-numbered gaps are
  // 'gap', even-numbered gaps are 'gap+delta'.
  bit ref_run = 1'b0;
  int gap = 20, delta = 0, ref_edges = 0, edge_cyc = 0;
  initial begin
    int pos, cur;
    pos = 0;
    cur = 20;
    forever begin
      @(negedge clk);
      if (!ref_run) begin
        ref_in = 1'b0;
        pos    = 0;
      end else begin
        if (pos == 0) begin
          ref_in    = 1'b1;
          ref_edges = ref_edges + 1;
          edge_cyc  = cyc;
          cur       = (ref_edges % 2 == 0) ? gap + delta : gap;
        end else if (pos == cur / 2) begin
          ref_in = 1'b0;
        end
        pos = pos + 1;
        if (pos >= cur) pos = 0;
      end
    end
  end

  int vld_last = 0, vld_prev = 0, ce_unlocked = 0;
  always @(negedge clk) begin
    if (period_vld) begin
      vld_prev <= vld_last;
      vld_last <= cyc;
    end
    if (ce_out != '0 && !lock) ce_unlocked <= ce_unlocked + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  // sel 0 waits on LOCK, sel 1 on REF_LOST.
  task automatic wait_sig(input int sel, input logic val, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (((sel == 0) ? lock : ref_lost) === val) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    ref_run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pd  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ref_edges = 0;
    ref_run   = 1'b1;
  endtask

  typedef struct {
    int gap;
    int delta;
    int exp_period;
    int exp_win;
    bit pd_pulse;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    logic [NCH-1:0] exp_ce;
    int t0;

    vecs[0] = '{20, 0, 20, 160, 1'b0};
    vecs[1] = '{17, 0, 17, 136, 1'b0};
    vecs[2] = '{20, 2, 21, 168, 1'b1};
    vecs[3] = '{20, 1, 20, 164, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_vld", period_vld, 0);
    check("rst_lock", lock, 0);
    check("rst_lost", ref_lost, 0);
    check("rst_ce", ce_out, 0);

    for (int v = 0; v < 4; v++) begin
      gap   = vecs[v].gap;
      delta = vecs[v].delta;
      do_reset();
      wait_sig(0, 1'b1, 3000, ok);
      check("lock_seen", ok, 1);
      check("lock_edge_no", ref_edges, 41);
      check("lock_latency", cyc - edge_cyc, 3);
      check("vld_with_lock", period_vld, 1);
      check("period", period, vecs[v].exp_period);
      #1;
      check("window_len", vld_last - vld_prev, vecs[v].exp_win);
      if (vecs[v].pd_pulse) begin
        pd = 1'b1;
        @(negedge clk);
        pd = 1'b0;
        check("pd_lock", lock, 0);
        check("pd_ce", ce_out, 0);
        check("pd_period_held", period, vecs[v].exp_period);
        check("pd_vld", period_vld, 0);
        check("pd_lost", ref_lost, 0);
      end
    end

    // Step from 20 to 25 exactly on a window boundary.
    gap = 20;
    delta = 0;
    do_reset();
    wait_sig(0, 1'b1, 3000, ok);
    check("step_lock20", ok, 1);
    for (int i = 0; i < 1000 && ref_edges < 48; i++) @(negedge clk);
    gap = 25;
    wait_sig(0, 1'b0, 800, ok);
    check("step_unlock", ok, 1);
    check("step_unlock_edge", ref_edges, 57);
    check("step_unlock_period", period, 25);
    check("step_unlock_vld", period_vld, 1);
    wait_sig(0, 1'b1, 1100, ok);
    check("step_relock", ok, 1);
    check("step_relock_edge", ref_edges, 89);
    check("step_relock_period", period, 25);

    // Reference stops: saturation after 2 sync flops + 65535 counts.
    ref_run = 1'b0;
    t0 = edge_cyc;
    wait_sig(1, 1'b1, 70000, ok);
    check("lost_seen", ok, 1);
    check("lost_time", cyc - t0, 65537);
    check("lost_lock", lock, 0);
    ref_run = 1'b1;
    wait_sig(1, 1'b0, 40, ok);
    check("lost_clear", ok, 1);
    check("lost_clear_time", cyc - edge_cyc, 3);

    // Divided strobes: ch0=4, ch1=3, ch2=1, ch3=0.
    gap = 20;
    div_o = {8'd0, 8'd1, 8'd3, 8'd4};
    do_reset();
    wait_sig(0, 1'b1, 3000, ok);
    check("div_lock", ok, 1);
    for (int e = 1; e <= 12; e++) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ce_out != '0) break;
      end
      exp_ce[0] = ((e - 1) % 4 == 0);
      exp_ce[1] = ((e - 1) % 3 == 0);
      exp_ce[2] = 1'b1;
      exp_ce[3] = 1'b1;
      check("ce_pattern", ce_out, exp_ce);
      @(negedge clk);
      check("ce_width", ce_out, 0);
    end

    // Asynchronous reset mid-window while locked.
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_period", period, 0);
    check("arst_lock", lock, 0);
    check("arst_ce", ce_out, 0);
    check("arst_vld", period_vld, 0);
    check("arst_lost", ref_lost, 0);
    do_reset();
    wait_sig(0, 1'b1, 3000, ok);
    check("arst_relock", ok, 1);
    check("arst_relock_edge", ref_edges, 41);
    check("arst_relock_period", period, 20);

    check("ce_while_unlocked", ce_unlocked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
